// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing source, the frame-synchronous data
// stage and the display stage.
//   - Default 640x480@60 Hz timing parameters and the constants derived from
//     them (totals, sync pulse start/end positions).
//   - 8-bit price/count typedefs shared with the matching engine.
//   - frame_stats_t: one snapshot of the engine statistics.
//   - sync_level(): maps a logical "pulse active" flag to the pin level.
// -----------------------------------------------------------------------------
package vga_pkg;

    // Default 640x480@60 Hz timing (25 MHz pixel clock)
    localparam int DEF_H_ACTIVE        = 640;
    localparam int DEF_H_FP            = 16;
    localparam int DEF_H_SYNC          = 96;
    localparam int DEF_H_BP            = 48;
    localparam int DEF_V_ACTIVE        = 480;
    localparam int DEF_V_FP            = 10;
    localparam int DEF_V_SYNC          = 2;
    localparam int DEF_V_BP            = 33;
    localparam int DEF_SYNC_ACTIVE_LOW = 1;

    // Derived timing constants for the default mode
    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;                          // 656
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;                    // 751
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;                          // 490
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;                    // 491

    typedef logic [7:0]  price_t;
    typedef logic [7:0]  count_t;
    typedef logic [9:0]  coord_t;
    typedef logic [15:0] frame_cnt_t;

    // One snapshot of the matching-engine statistics
    typedef struct packed {
        price_t buy;
        price_t sell;
        count_t trades;
        price_t spread;
        logic   halt;
    } frame_stats_t;

    // Pin level for a sync output given whether the pulse is currently active
    function automatic logic sync_level(input logic pulse, input bit active_low);
        return active_low ? ~pulse : pulse;
    endfunction

endpackage

// File: rtl/vga_sync_frame_latch_if.sv
// -----------------------------------------------------------------------------
// vga_sync_frame_latch_if
// Bundles the engine-side inputs and the display-side outputs of
// vga_sync_frame_latch.
//   master : engine / environment side (drives *_in, data_valid, preload hook;
//            observes timing and frame-stable data)
//   slave  : vga_sync_frame_latch itself
// Signals:
//   buy_price_in, sell_price_in, trade_count_in, spread_in, halt_in, data_valid
//   frame_count_load, frame_count_preload  - frame counter preload hook
//   h_cnt, v_cnt, video_on, hsync, vsync, frame_start, frame_count
//   buy_price, sell_price, trade_count, spread, halt_signal
// -----------------------------------------------------------------------------
interface vga_sync_frame_latch_if;
    import vga_pkg::*;

    // Engine side
    price_t     buy_price_in;
    price_t     sell_price_in;
    count_t     trade_count_in;
    price_t     spread_in;
    logic       halt_in;
    logic       data_valid;

    // Frame counter preload hook (synchronous load, wins over increment)
    logic       frame_count_load;
    frame_cnt_t frame_count_preload;

    // Display side
    coord_t     h_cnt;
    coord_t     v_cnt;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    frame_cnt_t frame_count;
    price_t     buy_price;
    price_t     sell_price;
    count_t     trade_count;
    price_t     spread;
    logic       halt_signal;

    modport master (
        output buy_price_in, sell_price_in, trade_count_in, spread_in,
               halt_in, data_valid, frame_count_load, frame_count_preload,
        input  h_cnt, v_cnt, video_on, hsync, vsync, frame_start, frame_count,
               buy_price, sell_price, trade_count, spread, halt_signal
    );

    modport slave (
        input  buy_price_in, sell_price_in, trade_count_in, spread_in,
               halt_in, data_valid, frame_count_load, frame_count_preload,
        output h_cnt, v_cnt, video_on, hsync, vsync, frame_start, frame_count,
               buy_price, sell_price, trade_count, spread, halt_signal
    );

endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster counters and sync generation for one video mode.
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt    current pixel column / line
//   video_on        pixel is inside the visible area
//   hsync, vsync    sync outputs at pin polarity
//   frame_start     1-cycle pulse while (h_cnt, v_cnt) = (0, 0) after a wrap
//   publish_now     the coming edge moves (last col, last visible line) to
//                   the first blanking line
//   frame_wrap      the coming edge moves the raster back to (0, 0)
// video_on/hsync/vsync/frame_start are registered from the next-count values,
// so every timing output describes the same pixel as h_cnt/v_cnt.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
    input  logic   clk,
    input  logic   rst_n,
    output coord_t h_cnt,
    output coord_t v_cnt,
    output logic   video_on,
    output logic   hsync,
    output logic   vsync,
    output logic   frame_start,
    output logic   publish_now,
    output logic   frame_wrap
);

    localparam coord_t H_LAST     = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST     = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VISIBLE  = coord_t'(H_ACTIVE);
    localparam coord_t V_VISIBLE  = coord_t'(V_ACTIVE);
    localparam coord_t H_SS       = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SE       = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t V_SS       = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SE       = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam coord_t V_PUB_LINE = coord_t'(V_ACTIVE - 1);
    localparam bit     ACTIVE_LOW = (SYNC_ACTIVE_LOW != 0);
    localparam logic   SYNC_IDLE  = sync_level(1'b0, ACTIVE_LOW);

    logic   h_wrap;
    coord_t h_nxt;
    coord_t v_nxt;

    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        h_wrap      = 1'b0;
        h_nxt       = h_cnt + coord_t'(1);
        v_nxt       = v_cnt;
        publish_now = 1'b0;
        frame_wrap  = 1'b0;

        if (h_cnt == H_LAST) begin
            h_wrap = 1'b1;
            h_nxt  = '0;
            v_nxt  = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
        end

        publish_now = h_wrap && (v_cnt == V_PUB_LINE);
        frame_wrap  = h_wrap && (v_cnt == V_LAST);
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            video_on    <= 1'b0;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            video_on    <= (h_nxt < H_VISIBLE) && (v_nxt < V_VISIBLE);
            hsync       <= sync_level((h_nxt >= H_SS) && (h_nxt <= H_SE), ACTIVE_LOW);
            vsync       <= sync_level((v_nxt >= V_SS) && (v_nxt <= V_SE), ACTIVE_LOW);
            // Reset value is (0,0) with frame_start low; only a real wrap pulses it
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

endmodule

// File: rtl/vga_sync_frame_latch.sv
// -----------------------------------------------------------------------------
// vga_sync_frame_latch
// VGA timing source plus frame-synchronous statistics stage feeding the display.
// Ports:
//   clk_25mhz   pixel clock (only clock)
//   rst_n       asynchronous active-low reset
//   bus         vga_sync_frame_latch_if.slave
//                 in : *_in statistics, data_valid strobe, frame count preload
//                 out: raster timing, frame_start/frame_count, frame-stable
//                      buy/sell price, trade count, spread, halt_signal
// Statistics are captured into a shadow on data_valid and republished only
// when the raster enters the first blanking line, so the visible area never
// shows a mix of old and new values. halt_signal is the exception: it rises
// as soon as a halt arrives and falls only at a publish with halt clear.
// -----------------------------------------------------------------------------
module vga_sync_frame_latch
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
    input  logic                   clk_25mhz,
    input  logic                   rst_n,
    vga_sync_frame_latch_if.slave  bus
);

    logic         publish_now;
    logic         frame_wrap;
    frame_stats_t shadow;
    frame_stats_t incoming;
    frame_stats_t pub_stats;

    vga_timing_gen #(
        .H_ACTIVE        (H_ACTIVE),
        .H_FP            (H_FP),
        .H_SYNC          (H_SYNC),
        .H_BP            (H_BP),
        .V_ACTIVE        (V_ACTIVE),
        .V_FP            (V_FP),
        .V_SYNC          (V_SYNC),
        .V_BP            (V_BP),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_timing (
        .clk         (clk_25mhz),
        .rst_n       (rst_n),
        .h_cnt       (bus.h_cnt),
        .v_cnt       (bus.v_cnt),
        .video_on    (bus.video_on),
        .hsync       (bus.hsync),
        .vsync       (bus.vsync),
        .frame_start (bus.frame_start),
        .publish_now (publish_now),
        .frame_wrap  (frame_wrap)
    );

    // A strobe on the publish edge bypasses the shadow so the freshest values
    // reach the display instead of the stale snapshot.
    always_comb begin
        incoming.buy    = bus.buy_price_in;
        incoming.sell   = bus.sell_price_in;
        incoming.trades = bus.trade_count_in;
        incoming.spread = bus.spread_in;
        incoming.halt   = bus.halt_in;
        pub_stats       = bus.data_valid ? incoming : shadow;
    end

    // NOTE: the shadow is a handful of flops, not a memory array, and must
    // come out of reset as zero so a reset mid-frame never republishes old data.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (bus.data_valid) begin
            shadow <= incoming;
        end
    end

    // Frame-stable data outputs
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            bus.buy_price   <= '0;
            bus.sell_price  <= '0;
            bus.trade_count <= '0;
            bus.spread      <= '0;
        end else if (publish_now) begin
            bus.buy_price   <= pub_stats.buy;
            bus.sell_price  <= pub_stats.sell;
            bus.trade_count <= pub_stats.trades;
            bus.spread      <= pub_stats.spread;
        end
    end

    // Halt rises immediately on a halt strobe; it only clears at a publish
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            bus.halt_signal <= 1'b0;
        end else if (publish_now) begin
            bus.halt_signal <= pub_stats.halt;
        end else if (bus.data_valid && bus.halt_in) begin
            bus.halt_signal <= 1'b1;
        end
    end

    // Frames completed; increments on the same edge frame_start rises
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            bus.frame_count <= '0;
        end else if (bus.frame_count_load) begin
            bus.frame_count <= bus.frame_count_preload;
        end else if (frame_wrap) begin
            bus.frame_count <= bus.frame_count + frame_cnt_t'(1);
        end
    end

endmodule

// File: tb/tb_vga_sync_frame_latch.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_frame_latch
// Directed bench for vga_sync_frame_latch. The DUT runs a reduced video mode
// (32 x 19 clocks per frame) so that several complete frames fit in a short
// run; all positions below are expressed in that mode:
//   visible 16x12, hsync active h=20..27, vsync active v=14..15,
//   publish edge (31,11)->(0,12), frame = 608 clocks.
// A small raster model checks every timing output each cycle; the data path
// is checked at hand-picked points with hand-computed values.
// -----------------------------------------------------------------------------
module tb_vga_sync_frame_latch;
    import vga_pkg::*;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HS  = 8;
    localparam int HBP = 4;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;   // 32
    localparam int VT  = VA + VFP + VS + VBP;   // 19

    logic clk;
    logic rst_n;

    int         n_checks;
    int         n_fail;
    int         exp_h;
    int         exp_v;
    logic [15:0] exp_fc;
    int         clocks_since_reset;
    int         hs_low_cnt;
    int         vs_low_cnt;

    vga_sync_frame_latch_if bus ();

    vga_sync_frame_latch #(
        .H_ACTIVE        (HA),
        .H_FP            (HFP),
        .H_SYNC          (HS),
        .H_BP            (HBP),
        .V_ACTIVE        (VA),
        .V_FP            (VFP),
        .V_SYNC          (VS),
        .V_BP            (VBP),
        .SYNC_ACTIVE_LOW (1)
    ) dut (
        .clk_25mhz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     tag, observed, observed, expected, expected, $time);
        end
    endtask

    // One clock; advance the raster model and check every timing output
    task automatic tick();
        logic wrapped;
        logic load_now;
        wrapped  = 1'b0;
        load_now = bus.frame_count_load;
        @(posedge clk);
        #1;
        clocks_since_reset++;
        if (exp_h == HT - 1) begin
            exp_h = 0;
            if (exp_v == VT - 1) begin
                exp_v   = 0;
                wrapped = 1'b1;
            end else begin
                exp_v++;
            end
        end else begin
            exp_h++;
        end
        if (load_now)     exp_fc = bus.frame_count_preload;
        else if (wrapped) exp_fc = exp_fc + 16'd1;

        check("h_cnt",       32'(bus.h_cnt), 32'(exp_h));
        check("v_cnt",       32'(bus.v_cnt), 32'(exp_v));
        check("video_on",    32'(bus.video_on), 32'((exp_h < HA) && (exp_v < VA)));
        check("hsync",       32'(bus.hsync),
              32'(!((exp_h >= HA + HFP) && (exp_h < HA + HFP + HS))));
        check("vsync",       32'(bus.vsync),
              32'(!((exp_v >= VA + VFP) && (exp_v < VA + VFP + VS))));
        check("frame_start", 32'(bus.frame_start), 32'((exp_h == 0) && (exp_v == 0)));
        check("frame_count", 32'(bus.frame_count), 32'(exp_fc));

        if (exp_fc == 16'd0) begin
            if (bus.hsync == 1'b0) hs_low_cnt++;
            if (bus.vsync == 1'b0) vs_low_cnt++;
        end
    endtask

    // Clock until the raster model sits at (h, v); bounded by one frame
    task automatic run_until(input int h, input int v);
        int n;
        n = 0;
        while (!(exp_h == h && exp_v == v) && n < HT * VT + 2) begin
            tick();
            n++;
        end
        check("run_until_reached", 32'(exp_h == h && exp_v == v), 32'd1);
    endtask

    // One data_valid cycle with the given statistics
    task automatic strobe(input int buy, input int sell, input int trades,
                          input int spread, input logic halt);
        bus.buy_price_in   = 8'(buy);
        bus.sell_price_in  = 8'(sell);
        bus.trade_count_in = 8'(trades);
        bus.spread_in      = 8'(spread);
        bus.halt_in        = halt;
        bus.data_valid     = 1'b1;
        tick();
        bus.data_valid     = 1'b0;
    endtask

    task automatic check_data(input string tag, input int buy, input int sell,
                              input int trades, input int spread, input logic halt);
        check({tag, "_buy"},    32'(bus.buy_price),   32'(buy));
        check({tag, "_sell"},   32'(bus.sell_price),  32'(sell));
        check({tag, "_trades"}, 32'(bus.trade_count), 32'(trades));
        check({tag, "_spread"}, 32'(bus.spread),      32'(spread));
        check({tag, "_halt"},   32'(bus.halt_signal), 32'(halt));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h"},     32'(bus.h_cnt),       32'd0);
        check({tag, "_v"},     32'(bus.v_cnt),       32'd0);
        check({tag, "_video"}, 32'(bus.video_on),    32'd0);
        check({tag, "_hsync"}, 32'(bus.hsync),       32'd1);
        check({tag, "_vsync"}, 32'(bus.vsync),       32'd1);
        check({tag, "_fs"},    32'(bus.frame_start), 32'd0);
        check({tag, "_fc"},    32'(bus.frame_count), 32'd0);
        check_data(tag, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_h    = 0;
        exp_v    = 0;
        exp_fc   = '0;
        clocks_since_reset = 0;
        hs_low_cnt = 0;
        vs_low_cnt = 0;

        bus.buy_price_in        = '0;
        bus.sell_price_in       = '0;
        bus.trade_count_in      = '0;
        bus.spread_in           = '0;
        bus.halt_in             = 1'b0;
        bus.data_valid          = 1'b0;
        bus.frame_count_load    = 1'b0;
        bus.frame_count_preload = '0;

        // Power-on reset
        rst_n = 1'b1;
        #5 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");

        @(negedge clk);
        rst_n = 1'b1;
        clocks_since_reset = 0;
        tick();
        check("first_edge_h",     32'(bus.h_cnt),    32'd1);
        check("first_edge_video", 32'(bus.video_on), 32'd1);

        // Frame 1: strobe at line 5 stays hidden until the publish edge
        run_until(3, 5);
        strobe(100, 110, 7, 10, 1'b0);
        check_data("f1_midframe", 0, 0, 0, 0, 1'b0);
        run_until(31, 11);
        check_data("f1_pre_publish", 0, 0, 0, 0, 1'b0);
        tick();
        check_data("f1_publish", 100, 110, 7, 10, 1'b0);
        run_until(0, 0);
        check("f1_frame_start", 32'(bus.frame_start), 32'd1);
        check("f1_frame_count", 32'(bus.frame_count), 32'd1);
        check("f1_frame_clocks", 32'(clocks_since_reset), 32'(HT * VT));
        check("f1_hsync_low_clocks", 32'(hs_low_cnt), 32'(HS * VT));
        check("f1_vsync_low_clocks", 32'(vs_low_cnt), 32'(VS * HT));

        // Frame 2: strobe on the publish edge beats the stale shadow (40)
        run_until(5, 3);
        strobe(40, 41, 42, 43, 1'b0);
        run_until(31, 11);
        check_data("f2_pre_publish", 100, 110, 7, 10, 1'b0);
        strobe(50, 51, 52, 53, 1'b0);
        check_data("f2_coincident", 50, 51, 52, 53, 1'b0);

        // Frame 3: halt rises mid-frame, prices still publish while halted
        run_until(0, 3);
        strobe(60, 61, 62, 63, 1'b1);
        check_data("f3_halt_set", 50, 51, 52, 53, 1'b1);
        run_until(31, 11);
        tick();
        check_data("f3_publish_halted", 60, 61, 62, 63, 1'b1);

        // Frame 4: halt clear waits for the publish edge
        run_until(0, 8);
        strobe(70, 71, 72, 73, 1'b0);
        check("f4_halt_held", 32'(bus.halt_signal), 32'd1);
        run_until(31, 11);
        check("f4_halt_pre_publish", 32'(bus.halt_signal), 32'd1);
        tick();
        check_data("f4_publish", 70, 71, 72, 73, 1'b0);

        // Frame 5: halted, shadow loaded, then reset mid-frame
        run_until(0, 2);
        strobe(80, 81, 82, 83, 1'b1);
        check("f5_halt_set", 32'(bus.halt_signal), 32'd1);
        run_until(10, 7);
        rst_n = 1'b0;
        #1;
        check_reset_state("midframe_rst");
        @(negedge clk);
        rst_n  = 1'b1;
        exp_h  = 0;
        exp_v  = 0;
        exp_fc = '0;
        tick();
        check("rst_resume_h", 32'(bus.h_cnt), 32'd1);
        check("rst_resume_v", 32'(bus.v_cnt), 32'd0);
        // Shadow was cleared by reset: first publish shows zeros, halt clear
        run_until(31, 11);
        tick();
        check_data("rst_publish", 0, 0, 0, 0, 1'b0);

        // Back-to-back strobes: last one wins
        run_until(4, 2);
        strobe(11, 21, 31, 41, 1'b0);
        strobe(12, 22, 32, 42, 1'b0);
        run_until(31, 11);
        tick();
        check_data("b2b_publish", 12, 22, 32, 42, 1'b0);

        // Frame counter wrap via the preload hook
        run_until(0, 14);
        bus.frame_count_preload = 16'hFFFF;
        bus.frame_count_load    = 1'b1;
        tick();
        bus.frame_count_load    = 1'b0;
        check("preload_value", 32'(bus.frame_count), 32'h0000_FFFF);
        run_until(0, 0);
        check("wrap_frame_start", 32'(bus.frame_start), 32'd1);
        check("wrap_frame_count", 32'(bus.frame_count), 32'd0);
        tick();
        check("wrap_frame_start_low", 32'(bus.frame_start), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
